// File: rtl/adc_serial_capture_if.sv
// adc_serial_capture_if
//   Groups the request, ADC serial pins and sample outputs of
//   adc_serial_capture into one bundle.
//   slave  : the capture block (drives CS_N/SCLK/DIN, D/E/BUSY)
//   master : the requester / ADC side (drives START, CH, ADC_DOUT)
//   Optional macro ADC_CHTAG_EN adds CH_OUT, the channel tag of D.
interface adc_serial_capture_if #(
  parameter int S    = 12,
  parameter int CH_W = 3
) ();
  logic            START;
  logic [CH_W-1:0] CH;
  logic            ADC_CS_N;
  logic            ADC_SCLK;
  logic            ADC_DIN;
  logic            ADC_DOUT;
  logic [S-1:0]    D;
  logic            E;
  logic            BUSY;
`ifdef ADC_CHTAG_EN
  logic [CH_W-1:0] CH_OUT;

  modport slave (
    input  START, CH, ADC_DOUT,
    output ADC_CS_N, ADC_SCLK, ADC_DIN, D, E, BUSY, CH_OUT
  );
  modport master (
    output START, CH, ADC_DOUT,
    input  ADC_CS_N, ADC_SCLK, ADC_DIN, D, E, BUSY, CH_OUT
  );
`else
  modport slave (
    input  START, CH, ADC_DOUT,
    output ADC_CS_N, ADC_SCLK, ADC_DIN, D, E, BUSY
  );
  modport master (
    output START, CH, ADC_DOUT,
    input  ADC_CS_N, ADC_SCLK, ADC_DIN, D, E, BUSY
  );
`endif
endinterface

// File: rtl/adc_serial_capture.sv
// adc_serial_capture
//   Serial front end for a 12-bit SPI ADC (ADC128S022-style framing).
//   One request runs one FRAME-SCLK conversion frame: the channel address
//   goes out on DIN during frame bits 2..4, and the last S bits of DOUT are
//   shifted in MSB first. The result is presented on D with a one-cycle
//   strobe E, suitable for a downstream enabled sample register.
//
// Ports
//   CLK            system clock, rising edge
//   CLR            synchronous active-high reset, overrides everything
//   bus (slave)    START, CH          request and channel (sampled in IDLE)
//                  ADC_CS_N, ADC_SCLK, ADC_DIN, ADC_DOUT   ADC serial pins
//                  D, E, BUSY         captured sample, strobe, frame active
//                  CH_OUT             channel tag of D (ADC_CHTAG_EN only)
//
// Optional macro: ADC_CHTAG_EN -- adds CH_OUT. The ADC returns the
// conversion of the channel addressed in the previous frame, so the tag is
// the channel latched one accepted frame earlier (0 after reset).
//
// All outputs are registered.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | CS_N high, SCLK high, waiting for START
// SETUP | CS_N low, first SCLK half-period before frame bit 0 falls
// SHIFT | SCLK toggling; address out on falls, data in on rises
module adc_serial_capture #(
  parameter int S       = 12,
  parameter int CLK_DIV = 4,
  parameter int FRAME   = 16,
  parameter int CH_W    = 3
) (
  input logic                CLK,
  input logic                CLR,
  adc_serial_capture_if.slave bus
);

  localparam int HP_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TG_W = $clog2(2 * FRAME + 1);
  localparam logic [HP_W-1:0] HP_LAST   = HP_W'(CLK_DIV - 1);
  localparam logic [TG_W-1:0] TG_END    = TG_W'(2 * FRAME);
  localparam logic [TG_W-1:0] BIT_FIRST = TG_W'(FRAME - S);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT
  } state_t;

  state_t          state_q, state_d;
  logic [HP_W-1:0] hp_q, hp_d;      // CLK count within an SCLK half-period
  logic [TG_W-1:0] tog_q, tog_d;    // SCLK toggles issued this frame
  logic [CH_W-1:0] ch_q, ch_d;
  logic [S-1:0]    sr_q, sr_d;
  logic            cs_n_q, cs_n_d;
  logic            sclk_q, sclk_d;
  logic            din_q, din_d;
  logic [S-1:0]    d_q, d_d;
  logic            e_q, e_d;
  logic            busy_q, busy_d;
`ifdef ADC_CHTAG_EN
  logic [CH_W-1:0] ch_prev_q, ch_prev_d;
  logic [CH_W-1:0] ch_out_q, ch_out_d;
`endif

  // Address field is always 3 bits on the wire; narrower CH zero-extends.
  logic [2:0]      addr3;
  logic [TG_W-1:0] bit_k;
  logic            hp_done;

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    tog_d   = tog_q;
    ch_d    = ch_q;
    sr_d    = sr_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    din_d   = din_q;
    d_d     = d_q;
    e_d     = 1'b0;
    busy_d  = busy_q;
`ifdef ADC_CHTAG_EN
    ch_prev_d = ch_prev_q;
    ch_out_d  = ch_out_q;
`endif
    addr3   = 3'(ch_q);
    bit_k   = tog_q >> 1;
    hp_done = (hp_q == HP_LAST);

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          state_d = SETUP;
          ch_d    = bus.CH;
`ifdef ADC_CHTAG_EN
          ch_prev_d = ch_q;
`endif
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          hp_d    = '0;
          tog_d   = '0;
          sr_d    = '0;
        end
      end

      SETUP, SHIFT: begin
        if (state_q == SHIFT && tog_q == TG_END) begin
          // One CLK after the final rising edge: hand off the word.
          state_d = IDLE;
          d_d     = sr_q;
          e_d     = 1'b1;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          sclk_d  = 1'b1;
          din_d   = 1'b0;
          hp_d    = '0;
          tog_d   = '0;
`ifdef ADC_CHTAG_EN
          ch_out_d = ch_prev_q;
`endif
        end else if (hp_done) begin
          state_d = SHIFT;
          hp_d    = '0;
          tog_d   = tog_q + 1'b1;
          sclk_d  = ~sclk_q;
          if (!tog_q[0]) begin
            // Falling edge of frame bit k: present the address bit.
            if (bit_k == TG_W'(2))      din_d = addr3[2];
            else if (bit_k == TG_W'(3)) din_d = addr3[1];
            else if (bit_k == TG_W'(4)) din_d = addr3[0];
            else                        din_d = 1'b0;
          end else if (bit_k >= BIT_FIRST) begin
            // Rising edge: only the trailing S bits carry the result.
            sr_d = {sr_q[S-2:0], bus.ADC_DOUT};
          end
        end else begin
          hp_d = hp_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= IDLE;
      hp_q    <= '0;
      tog_q   <= '0;
      ch_q    <= '0;
      sr_q    <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      din_q   <= 1'b0;
      d_q     <= '0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ADC_CHTAG_EN
      ch_prev_q <= '0;
      ch_out_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      tog_q   <= tog_d;
      ch_q    <= ch_d;
      sr_q    <= sr_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      din_q   <= din_d;
      d_q     <= d_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
`ifdef ADC_CHTAG_EN
      ch_prev_q <= ch_prev_d;
      ch_out_q  <= ch_out_d;
`endif
    end
  end

  assign bus.ADC_CS_N = cs_n_q;
  assign bus.ADC_SCLK = sclk_q;
  assign bus.ADC_DIN  = din_q;
  assign bus.D        = d_q;
  assign bus.E        = e_q;
  assign bus.BUSY     = busy_q;
`ifdef ADC_CHTAG_EN
  assign bus.CH_OUT   = ch_out_q;
`endif

endmodule

// File: tb/tb_adc_serial_capture.sv
// Bench for adc_serial_capture: dut0 uses defaults (CLK_DIV=4), dut1 uses
// CLK_DIV=1. Each has a small ADC model that returns queued words.
// Expected D values are queued when a frame is requested and popped at E.
module tb_adc_serial_capture;
  localparam int S     = 12;
  localparam int FRAME = 16;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  adc_serial_capture_if #(.S(S), .CH_W(3)) bus0 ();
  adc_serial_capture_if #(.S(S), .CH_W(3)) bus1 ();

  adc_serial_capture #(.S(S), .CLK_DIV(4), .FRAME(FRAME), .CH_W(3)) dut0 (
    .CLK(clk), .CLR(clr), .bus(bus0.slave));
  adc_serial_capture #(.S(S), .CLK_DIV(1), .FRAME(FRAME), .CH_W(3)) dut1 (
    .CLK(clk), .CLR(clr), .bus(bus1.slave));

  int errors = 0;
  int checks = 0;

  logic [S-1:0] wq0[$], wq1[$];     // words the ADC models will return
  logic [S-1:0] exp0[$], exp1[$];   // scoreboard of expected D
`ifdef ADC_CHTAG_EN
  logic [2:0]   expch0[$];
`endif

  // ADC model for dut0: drives DOUT after SCLK falls, records DIN at rise.
  logic [S-1:0] w0 = '0;
  int           k0 = 0;
  int           sclk_edges0 = 0;
  logic [15:0]  din_bits0 = '0;
  logic         p_cs0 = 1'b1, p_sclk0 = 1'b1;
  initial begin
    bus0.ADC_DOUT = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (p_cs0 === 1'b1 && bus0.ADC_CS_N === 1'b0) begin
        k0 = 0; sclk_edges0 = 0; din_bits0 = '0;
        w0 = (wq0.size() > 0) ? wq0.pop_front() : '0;
      end
      if (bus0.ADC_CS_N === 1'b0 && bus0.ADC_SCLK !== p_sclk0) sclk_edges0++;
      if (bus0.ADC_CS_N === 1'b0 && p_sclk0 === 1'b1 && bus0.ADC_SCLK === 1'b0)
        bus0.ADC_DOUT = (k0 >= FRAME - S && k0 < FRAME) ? w0[FRAME-1-k0] : 1'b0;
      if (bus0.ADC_CS_N === 1'b0 && p_sclk0 === 1'b0 && bus0.ADC_SCLK === 1'b1) begin
        if (k0 < 16) din_bits0[k0] = bus0.ADC_DIN;
        k0++;
      end
      p_cs0 = bus0.ADC_CS_N; p_sclk0 = bus0.ADC_SCLK;
    end
  end

  // ADC model for dut1 (data only).
  logic [S-1:0] w1 = '0;
  int           k1 = 0;
  logic         p_cs1 = 1'b1, p_sclk1 = 1'b1;
  initial begin
    bus1.ADC_DOUT = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (p_cs1 === 1'b1 && bus1.ADC_CS_N === 1'b0) begin
        k1 = 0;
        w1 = (wq1.size() > 0) ? wq1.pop_front() : '0;
      end
      if (bus1.ADC_CS_N === 1'b0 && p_sclk1 === 1'b1 && bus1.ADC_SCLK === 1'b0)
        bus1.ADC_DOUT = (k1 >= FRAME - S && k1 < FRAME) ? w1[FRAME-1-k1] : 1'b0;
      if (bus1.ADC_CS_N === 1'b0 && p_sclk1 === 1'b0 && bus1.ADC_SCLK === 1'b1) k1++;
      p_cs1 = bus1.ADC_CS_N; p_sclk1 = bus1.ADC_SCLK;
    end
  end

  // Request a dut0 frame (call right after a negedge).
  task automatic start0(input logic [2:0] ch, input logic [S-1:0] w, input bit expect_out);
    bus0.START = 1'b1;
    bus0.CH    = ch;
    wq0.push_back(w);
    if (expect_out) exp0.push_back(w);
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus0.START = 1'b1; bus0.CH = 3'd7;
    bus1.START = 1'b1; bus1.CH = 3'd7;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({bus0.ADC_CS_N, bus0.ADC_SCLK, bus0.ADC_DIN, bus0.E, bus0.BUSY, bus0.D} !==
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000}) begin
        errors++;
        $display("FAIL reset_dut0 cycle %0d: cs_n=%b sclk=%b din=%b e=%b busy=%b d=%h, want 1 1 0 0 0 000",
                 i, bus0.ADC_CS_N, bus0.ADC_SCLK, bus0.ADC_DIN, bus0.E, bus0.BUSY, bus0.D);
      end
      checks++;
      if ({bus1.ADC_CS_N, bus1.ADC_SCLK, bus1.ADC_DIN, bus1.E, bus1.BUSY, bus1.D} !==
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000}) begin
        errors++;
        $display("FAIL reset_dut1 cycle %0d: cs_n=%b sclk=%b din=%b e=%b busy=%b d=%h, want 1 1 0 0 0 000",
                 i, bus1.ADC_CS_N, bus1.ADC_SCLK, bus1.ADC_DIN, bus1.E, bus1.BUSY, bus1.D);
      end
    end
    clr = 1'b0;
    bus0.START = 1'b0;
    bus1.START = 1'b0;
  endtask

  // CH=5, word 0xA5C: E at 2*FRAME*CLK_DIV+1 = 129 cycles after the START edge.
  task automatic test_single();
    int e_cnt = 0, e_at = -1, cs_low = 0;
    bit d_early_bad = 1'b0;
    logic [S-1:0] exp;
    @(negedge clk);
    start0(3'd5, 12'hA5C, 1'b1);
    for (int m = 0; m < 200; m++) begin
      @(negedge clk);
      bus0.START = 1'b0;
      if (bus0.ADC_CS_N === 1'b0) cs_low++;
      if (bus0.E === 1'b1) begin
        e_cnt++;
        if (e_at < 0) e_at = m;
        checks++;
        if (exp0.size() == 0) begin
          errors++; $display("FAIL single_d: unexpected E, d=%h", bus0.D);
        end else begin
          exp = exp0.pop_front();
          if (bus0.D !== exp) begin
            errors++; $display("FAIL single_d: got %h want %h", bus0.D, exp);
          end
        end
      end else if (e_cnt == 0 && bus0.D !== 12'h000) d_early_bad = 1'b1;
    end
    checks++;
    if (e_cnt != 1) begin errors++; $display("FAIL single_e_count: got %0d want 1", e_cnt); end
    checks++;
    if (e_at != 129) begin errors++; $display("FAIL single_latency: got %0d want 129", e_at); end
    checks++;
    if (cs_low != 129) begin errors++; $display("FAIL single_cs_low: got %0d want 129", cs_low); end
    checks++;
    if (sclk_edges0 != 32) begin errors++; $display("FAIL single_sclk_edges: got %0d want 32", sclk_edges0); end
    checks++;
    if (din_bits0 !== 16'h0014) begin errors++; $display("FAIL single_din: got %h want 0014", din_bits0); end
    checks++;
    if (d_early_bad) begin errors++; $display("FAIL single_d_before_e: got changed want 000"); end
  endtask

  // START re-pulsed at cycles 10 and 60 of a busy frame must be ignored.
  task automatic test_busy_ignore();
    int e_cnt = 0, e_at = -1, cs_low = 0;
    logic [S-1:0] exp;
    @(negedge clk);
    start0(3'd2, 12'h3C7, 1'b1);
    for (int m = 0; m < 350; m++) begin
      @(negedge clk);
      bus0.START = (m == 10 || m == 60) ? 1'b1 : 1'b0;
      if (bus0.ADC_CS_N === 1'b0) cs_low++;
      if (bus0.E === 1'b1) begin
        e_cnt++;
        if (e_at < 0) e_at = m;
        checks++;
        if (exp0.size() == 0) begin
          errors++; $display("FAIL busy_d: unexpected E, d=%h", bus0.D);
        end else begin
          exp = exp0.pop_front();
          if (bus0.D !== exp) begin
            errors++; $display("FAIL busy_d: got %h want %h", bus0.D, exp);
          end
        end
      end
    end
    checks++;
    if (e_cnt != 1) begin errors++; $display("FAIL busy_e_count: got %0d want 1", e_cnt); end
    checks++;
    if (e_at != 129) begin errors++; $display("FAIL busy_latency: got %0d want 129", e_at); end
    checks++;
    if (cs_low != 129) begin errors++; $display("FAIL busy_cs_low: got %0d want 129", cs_low); end
    checks++;
    if (bus0.BUSY !== 1'b0) begin errors++; $display("FAIL busy_end_idle: got %b want 0", bus0.BUSY); end
  endtask

  // CLR during frame bit 9 (edges t0+76..t0+83) aborts the frame.
  task automatic test_clr_abort();
    int e_cnt = 0, e_at = -1;
    logic [S-1:0] exp;
    @(negedge clk);
    start0(3'd1, 12'h555, 1'b0);
    for (int m = 0; m < 250; m++) begin
      @(negedge clk);
      bus0.START = 1'b0;
      if (m == 77) clr = 1'b1;
      if (m == 78) begin
        clr = 1'b0;
        checks++;
        if ({bus0.ADC_CS_N, bus0.ADC_SCLK, bus0.BUSY} !== 3'b110) begin
          errors++;
          $display("FAIL abort_state: cs_n=%b sclk=%b busy=%b want 1 1 0",
                   bus0.ADC_CS_N, bus0.ADC_SCLK, bus0.BUSY);
        end
      end
      if (bus0.E === 1'b1) e_cnt++;
    end
    checks++;
    if (e_cnt != 0) begin errors++; $display("FAIL abort_no_e: got %0d pulses want 0", e_cnt); end
    checks++;
    if (bus0.D !== 12'h000) begin errors++; $display("FAIL abort_d: got %h want 000", bus0.D); end
    @(negedge clk);
    start0(3'd4, 12'h9E1, 1'b1);
    for (int m = 0; m < 200; m++) begin
      @(negedge clk);
      bus0.START = 1'b0;
      if (bus0.E === 1'b1) begin
        if (e_at < 0) e_at = m;
        checks++;
        if (exp0.size() == 0) begin
          errors++; $display("FAIL abort_next_d: unexpected E, d=%h", bus0.D);
        end else begin
          exp = exp0.pop_front();
          if (bus0.D !== exp) begin
            errors++; $display("FAIL abort_next_d: got %h want %h", bus0.D, exp);
          end
        end
      end
    end
    checks++;
    if (e_at != 129) begin errors++; $display("FAIL abort_next_latency: got %0d want 129", e_at); end
  endtask

  // dut1 (CLK_DIV=1), START held: frame = 33 cycles CS_N low + 1 high,
  // so E pulses are 34 cycles apart, first one 33 cycles after the START edge.
  task automatic test_back_to_back();
    int e_cnt = 0, cs_high = 0;
    int t_e[3];
    logic [S-1:0] exp;
    logic [S-1:0] words[3];
    words[0] = 12'h001; words[1] = 12'hFFF; words[2] = 12'h800;
    for (int i = 0; i < 3; i++) begin
      wq1.push_back(words[i]);
      exp1.push_back(words[i]);
    end
    @(negedge clk);
    bus1.START = 1'b1; bus1.CH = 3'd6;
    for (int m = 0; m < 200 && e_cnt < 3; m++) begin
      @(negedge clk);
      if (bus1.ADC_CS_N === 1'b1) cs_high++;
      if (bus1.E === 1'b1) begin
        t_e[e_cnt] = m;
        e_cnt++;
        if (e_cnt == 3) bus1.START = 1'b0;
        checks++;
        if (exp1.size() == 0) begin
          errors++; $display("FAIL b2b_d: unexpected E, d=%h", bus1.D);
        end else begin
          exp = exp1.pop_front();
          if (bus1.D !== exp) begin
            errors++; $display("FAIL b2b_d: pulse %0d got %h want %h", e_cnt, bus1.D, exp);
          end
        end
      end
    end
    bus1.START = 1'b0;
    checks++;
    if (e_cnt != 3) begin
      errors++; $display("FAIL b2b_e_count: got %0d want 3", e_cnt);
    end else begin
      checks++;
      if (t_e[0] != 33) begin errors++; $display("FAIL b2b_first: got %0d want 33", t_e[0]); end
      checks++;
      if (t_e[1] - t_e[0] != 34) begin errors++; $display("FAIL b2b_gap1: got %0d want 34", t_e[1] - t_e[0]); end
      checks++;
      if (t_e[2] - t_e[1] != 34) begin errors++; $display("FAIL b2b_gap2: got %0d want 34", t_e[2] - t_e[1]); end
      checks++;
      if (cs_high != 3) begin errors++; $display("FAIL b2b_cs_high: got %0d want 3", cs_high); end
    end
    repeat (40) @(negedge clk);
    checks++;
    if (bus1.BUSY !== 1'b0) begin errors++; $display("FAIL b2b_stop: busy=%b want 0", bus1.BUSY); end
  endtask

`ifdef ADC_CHTAG_EN
  // After reset the first tag is 0, then the channel of the previous frame.
  task automatic test_chtag();
    logic [S-1:0] exp;
    logic [2:0]   expc;
    logic [2:0]   chs[2];
    logic [S-1:0] ws[2];
    bit seen;
    chs[0] = 3'd3; chs[1] = 3'd6;
    ws[0] = 12'h123; ws[1] = 12'h456;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    expch0.push_back(3'd0);
    expch0.push_back(3'd3);
    for (int f = 0; f < 2; f++) begin
      seen = 1'b0;
      @(negedge clk);
      start0(chs[f], ws[f], 1'b1);
      for (int m = 0; m < 200 && !seen; m++) begin
        @(negedge clk);
        bus0.START = 1'b0;
        if (bus0.E === 1'b1) begin
          seen = 1'b1;
          exp  = exp0.pop_front();
          expc = expch0.pop_front();
          checks++;
          if (bus0.D !== exp) begin errors++; $display("FAIL chtag_d: got %h want %h", bus0.D, exp); end
          checks++;
          if (bus0.CH_OUT !== expc) begin errors++; $display("FAIL chtag_ch: got %0d want %0d", bus0.CH_OUT, expc); end
        end
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL chtag_timeout: frame %0d no E want E", f); end
    end
  endtask
`endif

  initial begin
    bus0.START = 1'b0; bus0.CH = '0;
    bus1.START = 1'b0; bus1.CH = '0;
    test_reset();
    test_single();
    test_busy_ignore();
    test_clr_abort();
    test_back_to_back();
`ifdef ADC_CHTAG_EN
    test_chtag();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
